// File: rtl/toggle_prescaler.sv
// rtl/toggle_prescaler.sv - programmable T-enable pulse generator for a downstream toggle flop (option: TPRE_ALIGNED_RELOAD_EN)
module toggle_prescaler #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [WIDTH-1:0] div_data,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             t,
  output logic             q_mirror,
  output logic [WIDTH-1:0] count,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             t_q, t_d;
  logic             qm_q, qm_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             rdy_q, rdy_d;

`ifdef TPRE_ALIGNED_RELOAD_EN
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
`endif

  logic [WIDTH-1:0] term;
  logic             at_tc;
  logic             xfer;

  // Next-state logic: FSM, terminal-count pulse, and divisor reload policy
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    t_d     = 1'b0;
    qm_d    = qm_q;
    div_d   = div_q;
    rdy_d   = 1'b1;
    // D = 0 is treated as D = 1, so the terminal count is 0 in both cases
    term    = (div_q == '0) ? '0 : (div_q - ONE);
    at_tc   = (count_q == term);
    xfer    = div_valid && rdy_q;
`ifdef TPRE_ALIGNED_RELOAD_EN
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
`endif

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          count_d = '0;
        end else if (at_tc) begin
          count_d = '0;
          t_d     = 1'b1;
          qm_d    = ~qm_q;
        end else begin
          count_d = count_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef TPRE_ALIGNED_RELOAD_EN
    // Pending divisor waits for a period boundary so pulse spacing is never cut short
    if (pend_vld_q && ((state_q == IDLE) || ((state_q == RUN) && run && at_tc))) begin
      div_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    if (xfer) begin
      pend_d     = div_data;
      pend_vld_d = 1'b1;
    end
    rdy_d = ~pend_vld_d;
`else
    // Immediate reload restarts the period; a coincident terminal-count pulse is dropped
    if (xfer) begin
      div_d   = div_data;
      count_d = '0;
      t_d     = 1'b0;
      qm_d    = qm_q;
    end
`endif
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      t_q     <= 1'b0;
      qm_q    <= 1'b0;
      div_q   <= RESET_DIV;
      rdy_q   <= 1'b0;
`ifdef TPRE_ALIGNED_RELOAD_EN
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      t_q     <= t_d;
      qm_q    <= qm_d;
      div_q   <= div_d;
      rdy_q   <= rdy_d;
`ifdef TPRE_ALIGNED_RELOAD_EN
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
`endif
    end
  end

  assign div_ready = rdy_q;
  assign t         = t_q;
  assign q_mirror  = qm_q;
  assign count     = count_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_toggle_prescaler.sv
// tb/tb_toggle_prescaler.sv - directed scoreboard bench for toggle_prescaler
module tb_toggle_prescaler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] div_data;
  logic       div_valid;
  logic       div_ready;
  logic       t;
  logic       q_mirror;
  logic [7:0] count;
  logic       busy;

  typedef struct packed {
    logic       busy;
    logic       rdy;
    logic       t;
    logic       q;
    logic [7:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  toggle_prescaler #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .div_data  (div_data),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .t         (t),
    .q_mirror  (q_mirror),
    .count     (count),
    .busy      (busy)
  );

  // Drive one edge's inputs, record what the outputs must be after it, then compare
  task automatic step(input logic r, input logic v, input logic [7:0] d, input string tag,
                      input logic eb, input logic er, input logic et, input logic eq,
                      input logic [7:0] ec);
    obs_t  o;
    obs_t  e;
    string tg;
    run       = r;
    div_valid = v;
    div_data  = d;
    exp_q.push_back('{busy: eb, rdy: er, t: et, q: eq, cnt: ec});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    o  = '{busy: busy, rdy: div_ready, t: t, q: q_mirror, cnt: count};
    e  = exp_q.pop_front();
    tg = tag_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed busy/rdy/t/q/cnt=%b%b%b%b/%0d expected=%b%b%b%b/%0d",
             tg, o.busy, o.rdy, o.t, o.q, o.cnt, e.busy, e.rdy, e.t, e.q, e.cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; div_valid = 1'b0; div_data = '0;

    step(0, 0, 0, "reset0", 0, 0, 0, 0, 0);
    step(1, 0, 0, "reset1", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // default D = 4: pulses after edges 4, 8, 12
    step(1, 0, 0, "start", 1, 1, 0, 0, 0);
    for (int k = 1; k <= 12; k++)
      step(1, 0, 0, "d4_run", 1, 1, (k % 4) == 0, ((k / 4) % 2) == 1, 8'(k % 4));

    // drop run at count = 2, then re-raise
    step(1, 0, 0, "pre_drop1", 1, 1, 0, 1, 1);
    step(1, 0, 0, "pre_drop2", 1, 1, 0, 1, 2);
    step(0, 0, 0, "drop", 0, 1, 0, 1, 0);
    step(0, 0, 0, "idle", 0, 1, 0, 1, 0);
    step(1, 0, 0, "reraise", 1, 1, 0, 1, 0);
    step(1, 0, 0, "rr1", 1, 1, 0, 1, 1);
    step(1, 0, 0, "rr2", 1, 1, 0, 1, 2);
    step(1, 0, 0, "rr3", 1, 1, 0, 1, 3);
    step(1, 0, 0, "rr_pulse", 1, 1, 1, 0, 0);

`ifdef TPRE_ALIGNED_RELOAD_EN
    // transfer D = 2 at count = 1: held until old period ends
    step(1, 0, 0, "al_c1", 1, 1, 0, 0, 1);
    step(1, 1, 2, "al_xfer", 1, 0, 0, 0, 2);
    step(1, 0, 0, "al_wait", 1, 0, 0, 0, 3);
    step(1, 0, 0, "al_apply", 1, 1, 1, 1, 0);
    step(1, 0, 0, "al_d2a", 1, 1, 0, 1, 1);
    step(1, 0, 0, "al_d2b", 1, 1, 1, 0, 0);
    step(1, 0, 0, "al_d2c", 1, 1, 0, 0, 1);
    // transfer D = 4 on a terminal-count edge: one more old period first
    step(1, 1, 4, "al_tcx", 1, 0, 1, 1, 0);
    step(1, 0, 0, "al_old", 1, 0, 0, 1, 1);
    step(1, 0, 0, "al_tcap", 1, 1, 1, 0, 0);
    step(1, 0, 0, "al_n1", 1, 1, 0, 0, 1);
    step(1, 0, 0, "al_n2", 1, 1, 0, 0, 2);
    step(1, 0, 0, "al_n3", 1, 1, 0, 0, 3);
    step(1, 0, 0, "al_n4", 1, 1, 1, 1, 0);
    // D = 0 behaves as D = 1 once applied
    step(1, 1, 0, "al_z_x", 1, 0, 0, 1, 1);
    step(1, 0, 0, "al_z_w2", 1, 0, 0, 1, 2);
    step(1, 0, 0, "al_z_w3", 1, 0, 0, 1, 3);
    step(1, 0, 0, "al_z_ap", 1, 1, 1, 0, 0);
    step(1, 0, 0, "al_z_p1", 1, 1, 1, 1, 0);
    step(1, 0, 0, "al_z_p2", 1, 1, 1, 0, 0);
    // restore D = 4 and leave D = 2 pending across a reset
    step(1, 1, 4, "al_r_x", 1, 0, 1, 1, 0);
    step(1, 0, 0, "al_r_ap", 1, 1, 1, 0, 0);
    step(1, 0, 0, "al_r_c1", 1, 1, 0, 0, 1);
    step(1, 1, 2, "al_r_pend", 1, 0, 0, 0, 2);
    rst_n = 1'b0;
    step(1, 0, 0, "al_rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0, "al_rs", 1, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      step(1, 0, 0, "al_post", 1, 1, (k % 4) == 0, ((k / 4) % 2) == 1, 8'(k % 4));
`else
    // D = 0 in RUN: pulse every cycle
    step(1, 1, 0, "im_d0x", 1, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      step(1, 0, 0, "im_d0", 1, 1, 1, (k % 2) == 1, 0);
    // D = 1 in RUN: pulse every cycle
    step(1, 1, 1, "im_d1x", 1, 1, 0, 0, 0);
    for (int k = 1; k <= 3; k++)
      step(1, 0, 0, "im_d1", 1, 1, 1, (k % 2) == 1, 0);
    // back to D = 4, then transfer D = 3 on a terminal-count edge
    step(1, 1, 4, "im_d4x", 1, 1, 0, 1, 0);
    step(1, 0, 0, "im_c1", 1, 1, 0, 1, 1);
    step(1, 0, 0, "im_c2", 1, 1, 0, 1, 2);
    step(1, 0, 0, "im_c3", 1, 1, 0, 1, 3);
    step(1, 1, 3, "im_tcx", 1, 1, 0, 1, 0);
    step(1, 0, 0, "im_d3a", 1, 1, 0, 1, 1);
    step(1, 0, 0, "im_d3b", 1, 1, 0, 1, 2);
    step(1, 0, 0, "im_d3p", 1, 1, 1, 0, 0);
    step(1, 0, 0, "im_d3c", 1, 1, 0, 0, 1);
    step(1, 0, 0, "im_d3d", 1, 1, 0, 0, 2);
    step(1, 0, 0, "im_d3q", 1, 1, 1, 1, 0);
    // reset mid-period with a transfer offered at the reset edge
    step(1, 0, 0, "im_pre", 1, 1, 0, 1, 1);
    rst_n = 1'b0;
    step(1, 1, 7, "im_rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0, "im_rs", 1, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      step(1, 0, 0, "im_post", 1, 1, (k % 4) == 0, ((k / 4) % 2) == 1, 8'(k % 4));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
